// File: rtl/idecode_stage.sv
// RV32I decode stage: field/immediate decode, 32x32 register file with write-through
// bypass, load-use hazard detection and the ID/EX pipeline register.
module idecode_stage (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] ir_i,
  input  logic        stall_v_i,
  input  logic        flush_v_i,
  input  logic        wb_w_v_i,
  input  logic [4:0]  wb_rd_i,
  input  logic [31:0] wb_data_i,
  output logic        stall_v_o,
  output logic        valid_o,
  output logic [6:0]  opcode_o,
  output logic [2:0]  funct3_o,
  output logic        funct7b5_o,
  output logic [4:0]  rd_o,
  output logic [31:0] rs1_data_o,
  output logic [31:0] rs2_data_o,
  output logic [31:0] imm_o,
  output logic        illegal_o
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic [6:0]  dec_opcode;
  logic [4:0]  rs1_addr, rs2_addr, dec_rd;
  logic        dec_valid, dec_illegal;
  logic        uses_rs1, uses_rs2, writes_rd;
  logic [31:0] dec_imm;
  logic [31:0] rs1_val, rs2_val;
  logic        hazard;
  logic [31:0] rf [32];

  assign dec_opcode = ir_i[6:0];
  assign rs1_addr   = ir_i[19:15];
  assign rs2_addr   = ir_i[24:20];
  assign dec_valid  = (ir_i != 32'h0);

  always_comb begin
    dec_imm     = '0;
    dec_illegal = 1'b0;
    uses_rs1    = 1'b0;
    uses_rs2    = 1'b0;
    writes_rd   = 1'b0;
    case (dec_opcode)
      OP_R: begin
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
        writes_rd = 1'b1;
      end
      OP_IMM, OP_LOAD, OP_JALR: begin
        dec_imm   = {{20{ir_i[31]}}, ir_i[31:20]};
        uses_rs1  = 1'b1;
        writes_rd = 1'b1;
      end
      OP_STORE: begin
        dec_imm  = {{20{ir_i[31]}}, ir_i[31:25], ir_i[11:7]};
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_BRANCH: begin
        dec_imm  = {{19{ir_i[31]}}, ir_i[31], ir_i[7], ir_i[30:25], ir_i[11:8], 1'b0};
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        dec_imm   = {ir_i[31:12], 12'h0};
        writes_rd = 1'b1;
      end
      OP_JAL: begin
        dec_imm   = {{11{ir_i[31]}}, ir_i[31], ir_i[19:12], ir_i[20], ir_i[30:21], 1'b0};
        writes_rd = 1'b1;
      end
      // The all-zero bubble also lands here and must not be flagged.
      default: dec_illegal = dec_valid;
    endcase
  end

  assign dec_rd = writes_rd ? ir_i[11:7] : 5'd0;

  // Register file; x0 is never written and always reads as zero.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (wb_w_v_i && (wb_rd_i != 5'd0)) begin
      rf[wb_rd_i] <= wb_data_i;
    end
  end

  always_comb begin
    rs1_val = rf[rs1_addr];
    rs2_val = rf[rs2_addr];
    if (wb_w_v_i && (wb_rd_i == rs1_addr)) rs1_val = wb_data_i;
    if (wb_w_v_i && (wb_rd_i == rs2_addr)) rs2_val = wb_data_i;
    if (rs1_addr == 5'd0) rs1_val = '0;
    if (rs2_addr == 5'd0) rs2_val = '0;
  end

  assign hazard = valid_o && (opcode_o == OP_LOAD) && (rd_o != 5'd0) &&
                  ((uses_rs1 && (rs1_addr == rd_o)) || (uses_rs2 && (rs2_addr == rd_o)));

  // Handshake with fetch: stall_v_o is the inverse of ready. ir_i is consumed on a
  // rising edge only when stall_v_o is low; while high, fetch must hold ir_i stable.
  assign stall_v_o = stall_v_i | (hazard & ~flush_v_i);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_o    <= 1'b0;
      illegal_o  <= 1'b0;
      opcode_o   <= '0;
      funct3_o   <= '0;
      funct7b5_o <= 1'b0;
      rd_o       <= '0;
      rs1_data_o <= '0;
      rs2_data_o <= '0;
      imm_o      <= '0;
    end else if (flush_v_i || (!stall_v_i && hazard)) begin
      // Flush and hazard bubble both leave a fully zeroed, invalid slot.
      valid_o    <= 1'b0;
      illegal_o  <= 1'b0;
      opcode_o   <= '0;
      funct3_o   <= '0;
      funct7b5_o <= 1'b0;
      rd_o       <= '0;
      rs1_data_o <= '0;
      rs2_data_o <= '0;
      imm_o      <= '0;
    end else if (!stall_v_i) begin
      valid_o    <= dec_valid;
      illegal_o  <= dec_illegal;
      opcode_o   <= dec_opcode;
      funct3_o   <= ir_i[14:12];
      funct7b5_o <= ir_i[30];
      rd_o       <= dec_rd;
      rs1_data_o <= rs1_val;
      rs2_data_o <= rs2_val;
      imm_o      <= dec_imm;
    end
  end

endmodule

// File: tb/tb_idecode_stage.sv
// Directed plus randomized bench for idecode_stage against an abstract model of
// the RV32I decode rules, register file and ID/EX pipeline register.
module tb_idecode_stage;

  typedef struct packed {
    logic        valid;
    logic        illegal;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        f7b5;
    logic [4:0]  rd;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic [31:0] imm;
  } idex_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [31:0] ir_i = '0;
  logic        stall_v_i = 1'b0, flush_v_i = 1'b0, wb_w_v_i = 1'b0;
  logic [4:0]  wb_rd_i = '0;
  logic [31:0] wb_data_i = '0;
  logic        stall_v_o, valid_o, funct7b5_o, illegal_o;
  logic [6:0]  opcode_o;
  logic [2:0]  funct3_o;
  logic [4:0]  rd_o;
  logic [31:0] rs1_data_o, rs2_data_o, imm_o;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mrf [32];
  idex_t       cur;
  idex_t       exp_q [$];
  logic        last_stall;
  logic        seen_stall;

  idecode_stage dut (
    .clk_i(clk_i), .rst_i(rst_i), .ir_i(ir_i), .stall_v_i(stall_v_i), .flush_v_i(flush_v_i),
    .wb_w_v_i(wb_w_v_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i), .stall_v_o(stall_v_o),
    .valid_o(valid_o), .opcode_o(opcode_o), .funct3_o(funct3_o), .funct7b5_o(funct7b5_o),
    .rd_o(rd_o), .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o), .imm_o(imm_o),
    .illegal_o(illegal_o)
  );

  // ---------------- clock ----------------
  always #5 clk_i = ~clk_i;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input idex_t e);
    check({tag, ".valid"},   32'(valid_o),    32'(e.valid));
    check({tag, ".illegal"}, 32'(illegal_o),  32'(e.illegal));
    check({tag, ".opcode"},  32'(opcode_o),   32'(e.opcode));
    check({tag, ".funct3"},  32'(funct3_o),   32'(e.funct3));
    check({tag, ".f7b5"},    32'(funct7b5_o), 32'(e.f7b5));
    check({tag, ".rd"},      32'(rd_o),       32'(e.rd));
    check({tag, ".rs1d"},    rs1_data_o,      e.rs1d);
    check({tag, ".rs2d"},    rs2_data_o,      e.rs2d);
    check({tag, ".imm"},     imm_o,           e.imm);
  endtask

  // ---------------- reference model ----------------
  // Decode by instruction format; operands come from the model register file,
  // which has already absorbed this cycle's writeback (write-through).
  task automatic model_decode(input logic [31:0] ir, output idex_t d, output bit u1, output bit u2);
    logic [31:0] sx;
    string fmt;
    sx = ir[31] ? 32'hFFFF_FFFF : 32'h0;
    case (ir[6:0])
      7'b0110011:                         fmt = "R";
      7'b0010011, 7'b0000011, 7'b1100111: fmt = "I";
      7'b0100011:                         fmt = "S";
      7'b1100011:                         fmt = "B";
      7'b0110111, 7'b0010111:             fmt = "U";
      7'b1101111:                         fmt = "J";
      default:                            fmt = "X";
    endcase
    d = '0;
    d.valid   = (ir != 0);
    d.illegal = (ir != 0) && (fmt == "X");
    d.opcode  = ir[6:0];
    d.funct3  = ir[14:12];
    d.f7b5    = ir[30];
    d.rd      = (fmt == "R" || fmt == "I" || fmt == "U" || fmt == "J") ? ir[11:7] : 5'd0;
    d.rs1d    = mrf[ir[19:15]];
    d.rs2d    = mrf[ir[24:20]];
    case (fmt)
      "I": d.imm = (sx << 12) | 32'(ir[31:20]);
      "S": d.imm = (sx << 12) | (32'(ir[31:25]) << 5) | 32'(ir[11:7]);
      "B": d.imm = (sx << 12) | (32'(ir[7]) << 11) | (32'(ir[30:25]) << 5) | (32'(ir[11:8]) << 1);
      "U": d.imm = ir & 32'hFFFF_F000;
      "J": d.imm = (sx << 20) | (32'(ir[19:12]) << 12) | (32'(ir[20]) << 11) | (32'(ir[30:21]) << 1);
      default: d.imm = 32'h0;
    endcase
    u1 = (fmt == "R" || fmt == "I" || fmt == "S" || fmt == "B");
    u2 = (fmt == "R" || fmt == "S" || fmt == "B");
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic [31:0] ir, input logic st, input logic fl,
                      input logic wv, input logic [4:0] wrd, input logic [31:0] wd);
    idex_t d, nxt;
    bit u1, u2, hz;
    logic exp_stall;
    @(negedge clk_i);
    ir_i = ir; stall_v_i = st; flush_v_i = fl;
    wb_w_v_i = wv; wb_rd_i = wrd; wb_data_i = wd;
    #1;
    if (wv && wrd != 0) mrf[wrd] = wd;
    model_decode(ir, d, u1, u2);
    hz = cur.valid && (cur.opcode == 7'b0000011) && (cur.rd != 0) &&
         ((u1 && ir[19:15] == cur.rd) || (u2 && ir[24:20] == cur.rd));
    exp_stall = st | (hz & ~fl);
    seen_stall = stall_v_o;
    check("stall_v_o", 32'(stall_v_o), 32'(exp_stall));
    last_stall = exp_stall;
    if (fl)      nxt = '0;
    else if (st) nxt = cur;
    else if (hz) nxt = '0;
    else         nxt = d;
    exp_q.push_back(nxt);
    cur = nxt;
    @(posedge clk_i);
    #1;
    check_outputs("idex", exp_q.pop_front());
  endtask

  task automatic apply_reset();
    @(negedge clk_i);
    #2;
    rst_i = 1'b0;
    #1;
    cur = '0;
    for (int i = 0; i < 32; i++) mrf[i] = '0;
    check_outputs("reset", cur);
    check("reset.stall", 32'(stall_v_o), 32'(stall_v_i));
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [9];
    logic [31:0] ir;
    int k;
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
            7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111};
    k = $urandom_range(0, 11);
    if (k >= 9) k = 2;
    if ($urandom_range(0, 9) == 0) return 32'h0;
    ir = $urandom;
    ir[6:0]   = ops[k];
    ir[11:7]  = 5'($urandom_range(0, 3));
    ir[19:15] = 5'($urandom_range(0, 3));
    ir[24:20] = 5'($urandom_range(0, 3));
    return ir;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    idex_t snap;
    logic [31:0] ir;
    cur = '0;
    last_stall = 1'b0;
    for (int i = 0; i < 32; i++) mrf[i] = '0;

    #1;
    check_outputs("por", cur);
    check("por.stall", 32'(stall_v_o), 32'h0);
    @(negedge clk_i);
    rst_i = 1'b1;

    // addi x1,x0,5
    step(32'h00500093, 0, 0, 0, 0, 0);
    check("addi.valid", 32'(valid_o), 32'h1);
    check("addi.opcode", 32'(opcode_o), 32'h13);
    check("addi.rd", 32'(rd_o), 32'h1);
    check("addi.imm", imm_o, 32'h5);
    check("addi.rs1d", rs1_data_o, 32'h0);

    // writeback bypass into addi x3,x2,0, then x0 write ignored
    step(32'h00010193, 0, 0, 1, 5'd2, 32'hDEADBEEF);
    check("bypass.rs1d", rs1_data_o, 32'hDEADBEEF);
    step(32'h00000013, 0, 0, 1, 5'd0, 32'h1234);
    step(32'h00000213, 0, 0, 0, 0, 0);
    check("x0.rs1d", rs1_data_o, 32'h0);

    // load-use: lw x5,0(x1) then add x6,x5,x0
    step(32'h0000A283, 0, 0, 0, 0, 0);
    step(32'h00028333, 0, 0, 0, 0, 0);
    check("lu.stall", 32'(seen_stall), 32'h1);
    check("lu.bubble", 32'(valid_o), 32'h0);
    step(32'h00028333, 0, 0, 0, 0, 0);
    check("lu.release", 32'(seen_stall), 32'h0);
    check("lu.valid", 32'(valid_o), 32'h1);
    check("lu.rd", 32'(rd_o), 32'h6);

    // immediates
    step(32'hFE000EE3, 0, 0, 0, 0, 0);
    check("beq.imm", imm_o, 32'hFFFFFFFC);
    check("beq.rd", 32'(rd_o), 32'h0);
    step(32'hABCDE3B7, 0, 0, 0, 0, 0);
    check("lui.imm", imm_o, 32'hABCDE000);
    check("lui.rd", 32'(rd_o), 32'h7);

    // downstream stall holds for three cycles
    snap = cur;
    for (int i = 0; i < 3; i++) begin
      step($urandom, 1, 0, 0, 0, 0);
      check("hold.valid", 32'(valid_o), 32'(snap.valid));
      check("hold.imm", imm_o, snap.imm);
      check("hold.rd", 32'(rd_o), 32'(snap.rd));
    end

    // flush together with a hazard
    step(32'h0000A283, 0, 0, 0, 0, 0);
    step(32'h00028333, 0, 1, 0, 0, 0);
    check("flush.stall", 32'(seen_stall), 32'h0);
    check("flush.valid", 32'(valid_o), 32'h0);

    // illegal and bubble
    step(32'hFFFFFFFF, 0, 0, 0, 0, 0);
    check("ill.illegal", 32'(illegal_o), 32'h1);
    check("ill.valid", 32'(valid_o), 32'h1);
    check("ill.rd", 32'(rd_o), 32'h0);
    step(32'h0, 0, 0, 0, 0, 0);
    check("bub.valid", 32'(valid_o), 32'h0);
    check("bub.illegal", 32'(illegal_o), 32'h0);

    // asynchronous reset mid-stream
    step(32'h00500093, 0, 0, 1, 5'd9, 32'h55AA55AA);
    apply_reset();
    check("arst.valid", 32'(valid_o), 32'h0);

    // randomized traffic; fetch holds ir_i while stall_v_o is high
    ir = rand_instr();
    for (int n = 0; n < 500; n++) begin
      if (!last_stall) ir = rand_instr();
      step(ir, ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 8),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/idecode_stage.md
# idecode_stage

Decode stage directly downstream of the instruction-fetch stage. It consumes the fetched instruction word and decodes RV32I fields and the immediate. It reads the 32x32 register file (write-through from writeback) and registers the result into the ID/EX pipeline register. It detects load-use hazards and back-pressures fetch with a stall, and honours downstream stall and branch flush.

## Interface
- No parameters; widths fixed by `rvga_word` (32 bits).
- clk_i  in  1  core clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- ir_i  in  32  instruction word from fetch; 32'h0 = bubble.
- stall_v_i  in  1  execute cannot accept; hold ID/EX register.
- flush_v_i  in  1  taken branch; kill instruction entering ID/EX.
- wb_w_v_i  in  1  register-file write enable.
- wb_rd_i  in  5  write address.
- wb_data_i  in  32  write data.
- stall_v_o  out  1  stall request to fetch.
- valid_o  out  1  ID/EX holds a real instruction.
- opcode_o  out  7  opcode field.
- funct3_o  out  3  funct3 field.
- funct7b5_o  out  1  ir[30].
- rd_o  out  5  destination register; 0 if the instruction does not write.
- rs1_data_o  out  32  rs1 operand.
- rs2_data_o  out  32  rs2 operand.
- imm_o  out  32  sign-extended immediate.
- illegal_o  out  1  unsupported opcode latched.

## Operation
- Decode is combinational from ir_i. Formats:
  - R = 0110011.
  - I = 0010011, 0000011 (LOAD), 1100111 (JALR).
  - S = 0100011.
  - B = 1100011.
  - U = 0110111 / 0010111.
  - J = 1101111.
- Immediates, all sign-extended from ir[31]:
  - I: ir[31:20].
  - S: {ir[31:25], ir[11:7]}.
  - B: {ir[31], ir[7], ir[30:25], ir[11:8], 0}.
  - U: {ir[31:12], 12'h0}.
  - J: {ir[31], ir[19:12], ir[20], ir[30:21], 0}.
  - R: 0.
- Register use:
  - uses_rs1 for every opcode except U and J.
  - uses_rs2 for R, S and B only.
  - writes_rd for R, I, U and J.
- Register file: 32x32, all entries cleared on reset.
  - x0 reads 0; writes to x0 are ignored.
  - Same-cycle write and read of the same register returns wb_data_i (write-through bypass).
- ir_i == 32'h0 is a bubble: valid 0, illegal 0.
  - Any other unlisted opcode is illegal: valid 1, illegal_o 1, rd_o 0.
- Load-use hazard condition: all of the following hold:
  - valid_o is 1.
  - opcode_o is LOAD.
  - rd_o is not 0.
  - (uses_rs1 and rs1 == rd_o) or (uses_rs2 and rs2 == rd_o).
- stall_v_o = stall_v_i | (hazard & ~flush_v_i).
- ID/EX update priority at each clock edge:
  1. flush_v_i: valid_o and illegal_o go to 0; other fields are don't-care but are zeroed.
  2. stall_v_i: all outputs hold.
  3. hazard: insert a bubble (valid_o=0, rd_o=0). ir_i is held upstream because stall_v_o=1.
  4. Otherwise load the decoded instruction.

## Timing
- Reset (rst_i low, asynchronous):
  - All ID/EX outputs are 0; valid_o=0, illegal_o=0.
  - stall_v_o follows its equation, so it is 0 when stall_v_i=0.
  - All register-file entries are 0.
  - Reset mid-operation discards the ID/EX contents immediately. No edge is needed.
- Latency: ir_i presented in cycle N appears on the ID/EX outputs after the edge ending cycle N.
- Register-file operands are sampled in cycle N, including a writeback in cycle N via bypass.
- A writeback in cycle N+1 is not seen by the instruction already latched. Forwarding belongs to execute.
- stall_v_o is combinational within the same cycle. A load-use hazard costs exactly one bubble cycle; the dependent instruction loads on the following edge.
- flush_v_i and hazard in the same cycle: flush wins and stall_v_o=stall_v_i.
- flush_v_i and stall_v_i in the same cycle: flush wins.

## Test plan
- Reset, then ir_i=32'h00500093 (addi x1,x0,5) -> after one edge:
  - valid_o=1, opcode_o=0010011, rd_o=1, imm_o=5, rs1_data_o=0.
- Writeback, then read of the same register:
  - Cycle 0 inputs: wb_w_v_i=1, wb_rd_i=2, wb_data_i=32'hDEADBEEF, ir_i=32'h00010193 (addi x3,x2,0).
  - Required: rs1_data_o=32'hDEADBEEF after that edge (bypass).
  - Write to x0 with 32'h1234: a later read of x0 is 0.
- Load-use:
  - Cycle 0: lw x5,0(x1) (32'h0000A283) is latched.
  - Cycle 1: ir_i=add x6,x5,x0 (32'h00028333).
  - Required: stall_v_o=1 in cycle 1, valid_o=0 after that edge, and the add is latched one edge later with stall_v_o=0.
- Immediate extraction:
  - beq with offset -4 (32'hFE000EE3): imm_o=32'hFFFFFFFC, rd_o=0.
  - lui x7,0xABCDE (32'hABCDE3B7): imm_o=32'hABCDE000.
- Flush and stall:
  - stall_v_i=1 for 3 cycles: outputs hold constant.
  - flush_v_i=1 asserted together with a hazard: valid_o=0 after the edge, stall_v_o=0.
- Illegal and bubble:
  - ir_i=32'hFFFFFFFF: illegal_o=1, valid_o=1.
  - ir_i=0: valid_o=0, illegal_o=0.
  - rst_i low mid-stream: valid_o drops to 0 without a clock edge.
